// File: rtl/qqspi_rcache_pkg.sv
// qqspi_rcache_pkg: shared states, widths and index/tag split helpers for the qqspi read cache
package qqspi_rcache_pkg;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_REQ,
        MEM_RELEASE,
        DONE
    } state_t;

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int lines);
        return ADDR_W - $clog2(lines);
    endfunction

endpackage

// File: rtl/rcache_store.sv
// rcache_store: direct-mapped line storage with byte-enable write, async read and one-cycle clear-all
module rcache_store
    import qqspi_rcache_pkg::*;
#(
    parameter int LINES = 64,
    localparam int IDX_W = idx_w(LINES),
    localparam int TAG_W = tag_w(LINES)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              we,
    input  logic              inv,
    input  logic [3:0]        wbe,
    input  logic [IDX_W-1:0]  idx,
    input  logic [TAG_W-1:0]  wtag,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [TAG_W-1:0]  rtag,
    output logic              rvalid
);

    logic [DATA_W-1:0] data [LINES];
    logic [TAG_W-1:0]  tags [LINES];
    logic [LINES-1:0]  vbits;

    assign rdata  = data[idx];
    assign rtag   = tags[idx];
    assign rvalid = vbits[idx];

    // data and tag arrays: byte-merged write, no reset needed since valid bits gate them
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (wbe[b]) data[idx][8*b +: 8] <= wdata[8*b +: 8];
            tags[idx] <= wtag;
        end
    end

    // valid bits: reset/flush clear everything, a write marks the line valid, inv drops one line
    always_ff @(posedge clk) begin
        if (!resetn || clear) vbits <= '0;
        else if (we) vbits[idx] <= 1'b1;
        else if (inv) vbits[idx] <= 1'b0;
    end

endmodule

// File: rtl/qqspi_rcache.sv
// qqspi_rcache: direct-mapped write-through read cache in front of qqspi
// Define QQSPI_RCACHE_WUPDATE_EN to merge write hits into the line instead of invalidating it.
module qqspi_rcache
    import qqspi_rcache_pkg::*;
#(
    parameter int LINES = 64,
    localparam int IDX_W = idx_w(LINES),
    localparam int TAG_W = tag_w(LINES)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              valid,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        wstrb,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    input  logic              flush,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            st;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;
    logic [DATA_W-1:0] s_rdata;
    logic [TAG_W-1:0]  s_tag;
    logic              s_valid;
    logic              is_rd;
    logic              hit;
    logic              mem_done;
    logic              s_we;
    logic              s_inv;

    assign is_rd    = wstrb_q == 4'h0;
    assign hit      = s_valid && s_tag == addr_q[ADDR_W-1:IDX_W];
    assign mem_done = st == MEM_REQ && mem_ready;

`ifdef QQSPI_RCACHE_WUPDATE_EN
    assign s_we  = mem_done && (is_rd || hit);
    assign s_inv = 1'b0;
`else
    assign s_we  = mem_done && is_rd;
    assign s_inv = mem_done && !is_rd && hit;
`endif

    rcache_store #(.LINES(LINES)) u_store (
        .clk    (clk),
        .resetn (resetn),
        .clear  (st == IDLE && flush),
        .we     (s_we),
        .inv    (s_inv),
        .wbe    (is_rd ? 4'hF : wstrb_q),
        .idx    (addr_q[IDX_W-1:0]),
        .wtag   (addr_q[ADDR_W-1:IDX_W]),
        .wdata  (is_rd ? mem_rdata : wdata_q),
        .rdata  (s_rdata),
        .rtag   (s_tag),
        .rvalid (s_valid)
    );

    // request sequencer; ready high in IDLE marks the completion cycle, so valid is ignored then
    always_ff @(posedge clk) begin
        if (!resetn) begin
            st        <= IDLE;
            ready     <= 1'b0;
            rdata     <= '0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            ready <= 1'b0;
            case (st)
                IDLE: if (!flush && valid && !ready) begin
                    addr_q  <= addr;
                    wdata_q <= wdata;
                    wstrb_q <= wstrb;
                    st      <= LOOKUP;
                end
                LOOKUP: if (is_rd && hit) begin
                    rdata <= s_rdata;
                    st    <= DONE;
                end else begin
                    mem_valid <= 1'b1;
                    mem_addr  <= addr_q;
                    mem_wdata <= wdata_q;
                    mem_wstrb <= wstrb_q;
                    st        <= MEM_REQ;
                end
                MEM_REQ: if (mem_ready) begin
                    mem_valid <= 1'b0;
                    if (is_rd) rdata <= mem_rdata;
                    st <= MEM_RELEASE;
                end
                MEM_RELEASE: if (!mem_ready) st <= DONE;
                DONE: begin
                    ready <= 1'b1;
                    st    <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qqspi_rcache.sv
// tb_qqspi_rcache: table-driven bench with a qqspi memory responder and an rdata scoreboard
module tb_qqspi_rcache;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        valid = 1'b0;
    logic [22:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        ready;
    logic [31:0] rdata;
    logic        flush = 1'b0;
    logic        mem_valid;
    logic [22:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    int passed = 0;
    int total = 0;
    int txn_cnt = 0;
    int ov_cnt = 0;
    int hold_len = 1;
    int ready_cycles = 0;
    int last_lat = 0;
    logic [22:0] last_addr = '0;
    logic [3:0]  last_wstrb = '0;
    logic [31:0] mem [int];
    logic [31:0] exp_q [$];

    typedef struct {
        logic [22:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] rd;
        int          tx;
        int          lat;
    } vec_t;
    vec_t tv [12];

    qqspi_rcache #(.LINES(64)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .valid     (valid),
        .addr      (addr),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .ready     (ready),
        .rdata     (rdata),
        .flush     (flush),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [22:0] a);
        return 32'hC0DE0000 ^ {9'h0, a};
    endfunction

    function automatic logic [31:0] mread(input logic [22:0] a);
        return mem.exists(int'(a)) ? mem[int'(a)] : init_val(a);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // qqspi model: accepts on mem_valid, holds mem_ready until mem_valid drops and hold_len cycles elapsed
    initial forever begin
        @(posedge clk); #1;
        if (!resetn) begin
            mem_ready = 1'b0;
        end else if (!mem_ready && mem_valid) begin
            logic [31:0] v;
            txn_cnt++;
            last_addr  = mem_addr;
            last_wstrb = mem_wstrb;
            v = mread(mem_addr);
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) v[8*b +: 8] = mem_wdata[8*b +: 8];
            if (mem_wstrb != 4'h0) mem[int'(mem_addr)] = v;
            mem_rdata = v;
            mem_ready = 1'b1;
            ready_cycles = 1;
        end else if (mem_ready) begin
            if (!mem_valid && ready_cycles >= hold_len) mem_ready = 1'b0;
            else ready_cycles++;
        end
    end

    // counts cycles where request and completion overlap; one per well-behaved transaction
    always @(negedge clk) if (mem_valid && mem_ready) ov_cnt++;

    task automatic do_req(input string nm, input logic [22:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [31:0] exp_rd, input int exp_tx,
                          input int exp_lat);
        int t0;
        int cyc;
        t0 = txn_cnt;
        exp_q.push_back(exp_rd);
        valid = 1'b1;
        addr = a;
        wdata = d;
        wstrb = s;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!ready && cyc < 200);
        valid = 1'b0;
        last_lat = cyc;
        if (!ready) begin
            check({nm, " timeout"}, {31'b0, ready}, 32'd1);
            void'(exp_q.pop_front());
        end else begin
            check({nm, " rdata"}, rdata, exp_q.pop_front());
            check({nm, " txns"}, txn_cnt - t0, exp_tx);
            check({nm, " latency"}, cyc, exp_lat);
            if (exp_tx > 0) begin
                check({nm, " mem_wstrb"}, {28'b0, last_wstrb}, {28'b0, s});
                check({nm, " mem_addr"}, {9'b0, last_addr}, {9'b0, a});
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ov0;
        mem[32'h10] = 32'hDEADBEEF;
        mem[32'h20] = 32'h11223344;
        tv[0]  = '{23'h000010, 32'h0, 4'h0, 32'hDEADBEEF, 1, 5};
        tv[1]  = '{23'h000010, 32'h0, 4'h0, 32'hDEADBEEF, 0, 3};
        tv[2]  = '{23'h000050, 32'h0, 4'h0, init_val(23'h50), 1, 5};
        tv[3]  = '{23'h000010, 32'h0, 4'h0, 32'hDEADBEEF, 1, 5};
        tv[4]  = '{23'h000050, 32'h0, 4'h0, init_val(23'h50), 1, 5};
        tv[5]  = '{23'h000020, 32'h0, 4'h0, 32'h11223344, 1, 5};
        tv[6]  = '{23'h000020, 32'h0000ABCD, 4'h3, 32'h11223344, 1, 5};
`ifdef QQSPI_RCACHE_WUPDATE_EN
        tv[7]  = '{23'h000020, 32'h0, 4'h0, 32'h1122ABCD, 0, 3};
`else
        tv[7]  = '{23'h000020, 32'h0, 4'h0, 32'h1122ABCD, 1, 5};
`endif
        tv[8]  = '{23'h7FFFFF, 32'h12345678, 4'hF, 32'h1122ABCD, 1, 5};
        tv[9]  = '{23'h7FFFFF, 32'h0, 4'h0, 32'h12345678, 1, 5};
        tv[10] = '{23'h7FFFFF, 32'h0, 4'h0, 32'h12345678, 0, 3};
        tv[11] = '{23'h000000, 32'h0, 4'h0, init_val(23'h0), 1, 5};

        repeat (3) @(posedge clk);
        #1;
        check("reset ready", {31'b0, ready}, 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset mem_valid", {31'b0, mem_valid}, 32'd0);
        check("reset mem_addr", {9'b0, mem_addr}, 32'd0);
        check("reset mem_wdata", mem_wdata, 32'd0);
        check("reset mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++)
            do_req($sformatf("row%0d", i), tv[i].a, tv[i].d, tv[i].s, tv[i].rd, tv[i].tx, tv[i].lat);

        for (int i = 1; i <= 4; i++)
            do_req($sformatf("warm%0d", i), 23'(i), 32'h0, 4'h0, init_val(23'(i)), 1, 5);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 1; i <= 4; i++)
            do_req($sformatf("postflush%0d", i), 23'(i), 32'h0, 4'h0, init_val(23'(i)), 1, 5);

        flush = 1'b1;
        fork
            begin
                @(posedge clk); #1;
                flush = 1'b0;
            end
        join_none
        do_req("flush_with_valid", 23'h5, 32'h0, 4'h0, init_val(23'h5), 1, 6);

        hold_len = 5;
        ov0 = ov_cnt;
        do_req("slow_ready", 23'h40, 32'h0, 4'h0, init_val(23'h40), 1, 9);
        check("slow_ready overlap cycles", ov_cnt - ov0, 32'd1);
        hold_len = 1;

        do_req("warm30", 23'h30, 32'h0, 4'h0, init_val(23'h30), 1, 5);
        valid = 1'b1;
        addr = 23'h70;
        wstrb = 4'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort mem_valid before reset", {31'b0, mem_valid}, 32'd1);
        resetn = 1'b0;
        valid = 1'b0;
        @(posedge clk); #1;
        check("abort mem_valid", {31'b0, mem_valid}, 32'd0);
        check("abort ready", {31'b0, ready}, 32'd0);
        check("abort rdata", rdata, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;
        do_req("after_reset", 23'h30, 32'h0, 4'h0, init_val(23'h30), 1, 5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
